// File: rtl/fifo_arq_pkg.sv
// Shared definitions for the SECDED ARQ FIFO: error-injection codes, FSM states and
// the Hamming parity-bit count helper.
package fifo_arq_pkg;

    localparam logic [1:0] ErrNone   = 2'b00;
    localparam logic [1:0] ErrSingle = 2'b01;
    localparam logic [1:0] ErrDouble = 2'b10;
    localparam logic [1:0] ErrFirst  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StResp
    } state_e;

    // Smallest P with 2^P >= data_width + P + 1.
    function automatic int unsigned secded_parity_bits(input int unsigned data_width);
        int unsigned p;
        p = 1;
        while ((32'd1 << p) < data_width + p + 1) p++;
        return p;
    endfunction

endpackage

// File: rtl/fifo_secded_arq_if.sv
// Host-side bundle of the SECDED ARQ FIFO: write/read handshake, responses, status and
// statistics. The host drives through master, the FIFO implements slave.
interface fifo_secded_arq_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [1:0]            err_mode;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ack;
    logic                  nack;
    logic                  drop;
    logic                  busy;
    logic                  full;
    logic                  empty;
    logic [LW-1:0]         level;
    logic [CNT_WIDTH-1:0]  corr_cnt;
    logic [CNT_WIDTH-1:0]  uncorr_cnt;
    logic [CNT_WIDTH-1:0]  drop_cnt;

    modport master (
        output wr_en, rd_en, data_in, err_mode,
        input  data_out, ack, nack, drop, busy, full, empty, level,
        input  corr_cnt, uncorr_cnt, drop_cnt
    );

    modport slave (
        input  wr_en, rd_en, data_in, err_mode,
        output data_out, ack, nack, drop, busy, full, empty, level,
        output corr_cnt, uncorr_cnt, drop_cnt
    );

endinterface

// File: rtl/secded_codec.sv
// Combinational Hamming SECDED codec. Codeword bit 0 is overall parity, bits 1..CW-1
// are Hamming positions with check bits at the powers of two.
module secded_codec
    import fifo_arq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned P  = secded_parity_bits(DATA_WIDTH),
    localparam int unsigned CW = DATA_WIDTH + P + 1
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CW-1:0]         cw_o,
    input  logic [CW-1:0]         cw_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  single_o,
    output logic                  double_o
);

    logic [CW-1:0] enc;
    logic [CW-1:0] fixed;
    logic [P-1:0]  syn;
    logic          par_bad;

    always_comb begin
        int unsigned k;
        enc = '0;
        k   = 0;
        for (int unsigned pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                enc[pos] = data_i[k];
                k++;
            end
        end
        for (int unsigned i = 0; i < P; i++) begin
            for (int unsigned pos = 1; pos < CW; pos++) begin
                if (((pos >> i) & 1) != 0 && pos != (32'd1 << i)) begin
                    enc[32'd1 << i] = enc[32'd1 << i] ^ enc[pos];
                end
            end
        end
        enc[0] = ^enc[CW-1:1];
        cw_o   = enc;
    end

    always_comb begin
        int unsigned k;
        syn = '0;
        for (int unsigned i = 0; i < P; i++) begin
            for (int unsigned pos = 1; pos < CW; pos++) begin
                if (((pos >> i) & 1) != 0) syn[i] = syn[i] ^ cw_i[pos];
            end
        end
        par_bad = ^cw_i;
        fixed   = cw_i;
        // Zero syndrome with bad parity means only the overall parity bit flipped.
        if (par_bad && syn != '0 && 32'(syn) < CW) fixed[syn] = ~fixed[syn];
        data_o = '0;
        k      = 0;
        for (int unsigned pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                data_o[k] = fixed[pos];
                k++;
            end
        end
        single_o = par_bad;
        double_o = (syn != '0) && !par_bad;
    end

endmodule

// File: rtl/fifo_secded_arq.sv
// SECDED-protected FIFO with per-read error injection and ack/nack retry (ARQ).
// Define FIFO_ARQ_STATS_EN to build the corrected/uncorrectable/drop statistics counters.
module fifo_secded_arq
    import fifo_arq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic               clk,
    input logic               rst,
    fifo_secded_arq_if.slave  bus
);

    localparam int unsigned P  = secded_parity_bits(DATA_WIDTH);
    localparam int unsigned CW = DATA_WIDTH + P + 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    state_e                state_q, state_d;
    logic [CW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [CW-1:0]         cw_q, cw_d;
    logic [3:0]            retry_q, retry_d;
    logic                  first_q, first_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  ack_q, ack_d, nack_q, nack_d, drop_q, drop_d;

    logic [CW-1:0]         wr_cw, inj_mask;
    logic [DATA_WIDTH-1:0] dec_data;
    logic                  dec_single, dec_double;
    logic                  push, pop, full, empty;

    logic [DATA_WIDTH-1:0] unused_enc_data;
    logic                  unused_enc_single, unused_enc_double;
    logic [CW-1:0]         unused_dec_cw;

    secded_codec #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
        .data_i   (bus.data_in),
        .cw_o     (wr_cw),
        .cw_i     ({CW{1'b0}}),
        .data_o   (unused_enc_data),
        .single_o (unused_enc_single),
        .double_o (unused_enc_double)
    );

    secded_codec #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
        .data_i   ({DATA_WIDTH{1'b0}}),
        .cw_o     (unused_dec_cw),
        .cw_i     (cw_q),
        .data_o   (dec_data),
        .single_o (dec_single),
        .double_o (dec_double)
    );

    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        cw_d       = cw_q;
        retry_d    = retry_q;
        first_d    = first_q;
        data_out_d = data_out_q;
        ack_d      = 1'b0;
        nack_d     = 1'b0;
        drop_d     = 1'b0;
        pop        = 1'b0;
        inj_mask   = '0;

        case (bus.err_mode)
            ErrNone:   inj_mask      = '0;
            ErrSingle: inj_mask[0]   = 1'b1;
            ErrDouble: inj_mask[1:0] = 2'b11;
            ErrFirst:  inj_mask[1:0] = {2{first_q}};
            default:   inj_mask      = '0;
        endcase

        unique case (state_q)
            StIdle: begin
                if (bus.rd_en && !empty) begin
                    cw_d    = mem_q[rd_ptr_q] ^ inj_mask;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StResp;
                if (!dec_double) begin
                    ack_d      = 1'b1;
                    data_out_d = dec_data;
                    pop        = 1'b1;
                end else begin
                    nack_d  = 1'b1;
                    retry_d = retry_q + 4'd1;
                    first_d = 1'b0;
                    if (retry_d == 4'(MAX_RETRY)) begin
                        drop_d = 1'b1;
                        pop    = 1'b1;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            retry_d  = '0;
            first_d  = 1'b1;
        end

        // A pop frees the head slot this cycle, so a full buffer can still take a push.
        push = bus.wr_en && (!full || pop);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);

        if (push && !pop)      level_d = level_q + LW'(1);
        else if (!push && pop) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cw_q       <= '0;
            retry_q    <= '0;
            first_q    <= 1'b1;
            data_out_q <= '0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cw_q       <= cw_d;
            retry_q    <= retry_d;
            first_q    <= first_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_cw;
    end

    assign bus.data_out = data_out_q;
    assign bus.ack      = ack_q;
    assign bus.nack     = nack_q;
    assign bus.drop     = drop_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level_q;

`ifdef FIFO_ARQ_STATS_EN
    logic [CNT_WIDTH-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_WIDTH-1:0] uncorr_cnt_q, uncorr_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        if (ack_d && dec_single && corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
        if (nack_d && uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + CNT_WIDTH'(1);
        if (drop_d && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.corr_cnt   = corr_cnt_q;
    assign bus.uncorr_cnt = uncorr_cnt_q;
    assign bus.drop_cnt   = drop_cnt_q;
`else
    logic unused_dec_single;
    assign unused_dec_single = dec_single;

    assign bus.corr_cnt   = {CNT_WIDTH{1'b0}};
    assign bus.uncorr_cnt = {CNT_WIDTH{1'b0}};
    assign bus.drop_cnt   = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_secded_arq.sv
// Scoreboard bench for fifo_secded_arq: reads push expected responses, a negedge monitor
// pops and checks them when ack/nack/drop pulse.
module tb_fifo_secded_arq;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXR  = 3;
    localparam int unsigned CNTW  = 8;

    typedef struct {
        bit         ack;
        bit         nack;
        bit         drop;
        logic [7:0] data;
        int         due;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    resp_t      exp_q[$];
    logic [7:0] mdl_q[$];
    resp_t      mon_e;
    int         m_retry, m_corr, m_uncorr, m_drop;
    bit         m_first;
    logic [7:0] m_dout;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_secded_arq_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CNTW)) bus ();

    fifo_secded_arq #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .MAX_RETRY  (MAXR),
        .CNT_WIDTH  (CNTW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int cnt_exp(input int v);
`ifdef FIFO_ARQ_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Scoreboard monitor: every response pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (!rst && (bus.ack || bus.nack || bus.drop)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: ack=%0b nack=%0b drop=%0b, none outstanding",
                         bus.ack, bus.nack, bus.drop);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.ack, bus.nack, bus.drop} !== {mon_e.ack, mon_e.nack, mon_e.drop}) begin
                    n_err++;
                    $display("FAIL resp_kind: got ack/nack/drop=%b%b%b want %b%b%b",
                             bus.ack, bus.nack, bus.drop, mon_e.ack, mon_e.nack, mon_e.drop);
                end
                n_cmp++;
                if (bus.data_out !== mon_e.data) begin
                    n_err++;
                    $display("FAIL resp_data: got %h want %h", bus.data_out, mon_e.data);
                end
                n_cmp++;
                if (cyc != mon_e.due) begin
                    n_err++;
                    $display("FAIL resp_latency: got cycle %0d want %0d", cyc, mon_e.due);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.data_in  = '0;
        bus.err_mode = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl_q.delete();
        exp_q.delete();
        m_retry  = 0;
        m_first  = 1'b1;
        m_corr   = 0;
        m_uncorr = 0;
        m_drop   = 0;
        m_dout   = 8'h00;
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.data_in = d;
        if (mdl_q.size() < DEPTH) mdl_q.push_back(d);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Issue one read and record the expected response; returns in the response cycle.
    task automatic rd(input logic [1:0] mode);
        resp_t e;
        bit    dbl;
        @(negedge clk);
        bus.rd_en    = 1'b1;
        bus.err_mode = mode;
        dbl   = (mode == 2'b10) || (mode == 2'b11 && m_first);
        e.due = cyc + 2;
        if (!dbl) begin
            e.ack  = 1'b1; e.nack = 1'b0; e.drop = 1'b0;
            e.data = mdl_q.pop_front();
            m_dout = e.data;
            if (mode == 2'b01) m_corr++;
            m_retry = 0; m_first = 1'b1;
        end else begin
            e.ack  = 1'b0; e.nack = 1'b1; e.drop = 1'b0;
            e.data = m_dout;
            m_uncorr++; m_retry++; m_first = 1'b0;
            if (m_retry == MAXR) begin
                e.drop = 1'b1;
                m_drop++;
                void'(mdl_q.pop_front());
                m_retry = 0; m_first = 1'b1;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({bus.ack, bus.nack, bus.drop, bus.busy, bus.full, bus.empty} !== 6'b000001) begin
            n_err++;
            $display("FAIL reset_flags: got a/n/d/busy/full/empty=%b want 000001",
                     {bus.ack, bus.nack, bus.drop, bus.busy, bus.full, bus.empty});
        end
        n_cmp++;
        if (bus.level !== 3'd0 || bus.data_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_level_data: got level=%0d data=%h want 0/00",
                     bus.level, bus.data_out);
        end
        n_cmp++;
        if ({bus.corr_cnt, bus.uncorr_cnt, bus.drop_cnt} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_counters: got %h/%h/%h want 0",
                     bus.corr_cnt, bus.uncorr_cnt, bus.drop_cnt);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        foreach (vals[i]) wr(vals[i]);
        n_cmp++;
        if (bus.level !== 3'd4 || bus.full !== 1'b1 || bus.empty !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: got level=%0d full=%b empty=%b want 4/1/0",
                     bus.level, bus.full, bus.empty);
        end
        wr(8'h11);
        n_cmp++;
        if (bus.level !== 3'd4 || bus.full !== 1'b1) begin
            n_err++;
            $display("FAIL write_when_full: got level=%0d full=%b want 4/1", bus.level, bus.full);
        end
        repeat (4) rd(2'b00);
        @(negedge clk);
        n_cmp++;
        if (bus.empty !== 1'b1 || bus.level !== 3'd0) begin
            n_err++;
            $display("FAIL drain_empty: got empty=%b level=%0d want 1/0", bus.empty, bus.level);
        end
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL read_when_empty: got busy=%b want 0", bus.busy);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL fill_pending: got %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_single();
        wr(8'h5A);
        rd(2'b01);
        n_cmp++;
        if (bus.level !== 3'd0) begin
            n_err++;
            $display("FAIL single_level: got %0d want 0", bus.level);
        end
        n_cmp++;
        if (bus.corr_cnt !== 8'(cnt_exp(m_corr))) begin
            n_err++;
            $display("FAIL single_corr_cnt: got %0d want %0d", bus.corr_cnt, cnt_exp(m_corr));
        end
    endtask

    task automatic test_double_drop();
        wr(8'h77);
        for (int r = 1; r <= 3; r++) begin
            rd(2'b10);
            n_cmp++;
            if (bus.level !== 3'(mdl_q.size()) || bus.data_out !== m_dout) begin
                n_err++;
                $display("FAIL double_read%0d: got level=%0d data=%h want %0d/%h",
                         r, bus.level, bus.data_out, mdl_q.size(), m_dout);
            end
        end
        n_cmp++;
        if (bus.empty !== 1'b1) begin
            n_err++;
            $display("FAIL drop_empty: got %b want 1", bus.empty);
        end
        n_cmp++;
        if (bus.uncorr_cnt !== 8'(cnt_exp(m_uncorr)) || bus.drop_cnt !== 8'(cnt_exp(m_drop))) begin
            n_err++;
            $display("FAIL drop_counters: got uncorr=%0d drop=%0d want %0d/%0d", bus.uncorr_cnt,
                     bus.drop_cnt, cnt_exp(m_uncorr), cnt_exp(m_drop));
        end
    endtask

    task automatic test_first_only();
        apply_reset();
        wr(8'h81);
        rd(2'b11);
        n_cmp++;
        if (bus.level !== 3'd1) begin
            n_err++;
            $display("FAIL first_retry_level: got %0d want 1", bus.level);
        end
        rd(2'b11);
        n_cmp++;
        if (bus.uncorr_cnt !== 8'(cnt_exp(m_uncorr)) || bus.drop_cnt !== 8'(cnt_exp(m_drop))
            || bus.empty !== 1'b1) begin
            n_err++;
            $display("FAIL first_counters: got uncorr=%0d drop=%0d empty=%b want %0d/%0d/1",
                     bus.uncorr_cnt, bus.drop_cnt, bus.empty, cnt_exp(m_uncorr),
                     cnt_exp(m_drop));
        end
    endtask

    task automatic test_back_to_back();
        resp_t e;
        for (int i = 1; i <= 4; i++) wr(8'(i));
        @(negedge clk);
        bus.rd_en    = 1'b1;
        bus.err_mode = 2'b00;
        e.ack = 1'b1; e.nack = 1'b0; e.drop = 1'b0;
        e.data = mdl_q.pop_front();
        e.due  = cyc + 2;
        m_dout = e.data;
        exp_q.push_back(e);
        @(negedge clk);
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b1;
        bus.data_in = 8'h42;
        mdl_q.push_back(8'h42);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (bus.level !== 3'd4 || bus.full !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_level_c%0d: got level=%0d full=%b want 4/1",
                         c, bus.level, bus.full);
            end
            @(negedge clk);
            bus.wr_en = 1'b0;
        end
        repeat (3) rd(2'b00);
        wr(8'h05);
        wr(8'h06);
        repeat (3) rd(2'b00);
        @(negedge clk);
        n_cmp++;
        if (bus.empty !== 1'b1 || exp_q.size() != 0 || mdl_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_drain: got empty=%b outstanding=%0d want 1/0",
                     bus.empty, exp_q.size());
        end
    endtask

    task automatic test_abort();
        wr(8'h99);
        @(negedge clk);
        bus.rd_en    = 1'b1;
        bus.err_mode = 2'b00;
        @(negedge clk);
        bus.rd_en = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_in_decode: got busy=%b want 1", bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_q.delete();
        m_dout = 8'h00;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({bus.ack, bus.nack, bus.drop, bus.busy, bus.full, bus.empty} !== 6'b000001
                || bus.level !== 3'd0 || bus.data_out !== 8'h00
                || {bus.corr_cnt, bus.uncorr_cnt, bus.drop_cnt} !== 24'h0) begin
                n_err++;
                $display("FAIL abort_c%0d: got flags=%b level=%0d data=%h cnts=%h/%h/%h",
                         c, {bus.ack, bus.nack, bus.drop, bus.busy, bus.full, bus.empty},
                         bus.level, bus.data_out, bus.corr_cnt, bus.uncorr_cnt, bus.drop_cnt);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.data_in  = '0;
        bus.err_mode = 2'b00;
        test_reset();
        test_fill_drain();
        test_single();
        test_double_drop();
        test_first_only();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_secded_arq.md
Name: fifo_secded_arq

Overview:
- Parametrised successor to the fixed 8-bit/4-deep hazard FIFO.
- Writes are Hamming-SECDED encoded into a circular buffer.
- Each read is decoded through a per-read error-injection channel and answered with an ack or nack pulse.
- Nacked entries stay queued for retry (ARQ) until MAX_RETRY is exhausted, then they are dropped. Sits between the pad wrapper and the test host.

Parameters:
- DATA_WIDTH, 8, payload bits (2..32).
- FIFO_DEPTH, 4, entries; power of two, >=2.
- MAX_RETRY, 3, nacks allowed per entry before drop (1..15).
- CNT_WIDTH, 8, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push data_in when !full.
- rd_en  in  1  start a read attempt when state IDLE and !empty.
- data_in  in  DATA_WIDTH  payload.
- err_mode  in  2  injection: 00 none, 01 single-bit, 10 double-bit, 11 double-bit on first attempt only.
- data_out  out  DATA_WIDTH  corrected payload; holds its value between reads.
- ack  out  1  one-cycle pulse: read good or corrected.
- nack  out  1  one-cycle pulse: uncorrectable.
- drop  out  1  one-cycle pulse coincident with the final nack; entry discarded.
- busy  out  1  state != IDLE.
- full  out  1  buffer full.
- empty  out  1  buffer empty.
- level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- corr_cnt  out  CNT_WIDTH  corrected single-bit errors.
- uncorr_cnt  out  CNT_WIDTH  nacks.
- drop_cnt  out  CNT_WIDTH  drops.

Behaviour:
- Codeword width: CW = DATA_WIDTH + P + 1, where P is the minimum value with 2^P >= DATA_WIDTH+P+1, plus one overall parity bit. DATA_WIDTH=8 gives CW=13.
- Reset: ptrs=0, level=0, empty=1, full=0, state=IDLE, data_out=0, ack=nack=drop=busy=0, counters=0, retry count=0, first-attempt flag=1.
- Write:
  - wr_en && !full stores encode(data_in) at wr_ptr; wr_ptr increments mod FIFO_DEPTH.
  - wr_en while full is ignored, with no state change.
- FSM IDLE -> DECODE -> RESP -> IDLE:
  - IDLE: rd_en && !empty latches cw = mem[rd_ptr] ^ inject_mask, then go to DECODE. rd_en while empty or busy is ignored.
  - DECODE: compute syndrome and overall parity; register the result, then go to RESP.
  - RESP: drive a single-cycle pulse, then return to IDLE. rd_en is accepted again the next cycle.
  - Latency: rd_en at cycle N gives ack/nack at N+2.
- inject_mask:
  - 00: 0.
  - 01: bit 0 flipped.
  - 10: bits 0 and 1 flipped.
  - 11: bits 0 and 1 flipped if the entry's first-attempt flag is set, else 0.
- Decode outcomes in RESP:
  - Syndrome 0 and parity ok: ack; data_out = data; pop.
  - Parity bad (single error, including an error in the parity bit itself): correct the bit; ack; data_out = corrected data; pop; corr_cnt++.
  - Syndrome !=0 and parity ok (double error): nack; data_out unchanged; uncorr_cnt++; retry count++; first-attempt flag cleared.
    - Retry count now < MAX_RETRY: no pop.
    - Retry count now == MAX_RETRY: also drop pulse and pop; drop_cnt++.
- Pop: rd_ptr++ mod depth; retry count=0; first-attempt flag=1.
- Same-cycle push and pop: level unchanged; full/empty unchanged.
- Wrap-around: both ptrs use log2(FIFO_DEPTH) bits. full/empty are derived from level, never from a ptr compare.
- Counters saturate at all-ones.
- rst asserted mid-read aborts the read with no ack/nack and returns to the reset state. Buffer contents are don't-care.

Optional Feature:
- FIFO_ARQ_STATS_EN defined: corr_cnt, uncorr_cnt and drop_cnt are live as specified.
- Undefined: the counter registers are not built, the three ports are tied to 0, and ack/nack/drop behaviour is unchanged.

Decomposition:
- Package fifo_arq_pkg holds:
  - err_mode encoding constants.
  - FSM state enum (IDLE, DECODE, RESP).
  - Function secded_parity_bits(DATA_WIDTH) returning P.
- One sub-module, secded_codec, contains the combinational encode and the decode (syndrome, single/double flags, corrected data). It is instantiated once for the write path and once for the read path.

Test Plan:
1. Reset, write 0xA5, 0x3C, 0xFF, 0x00 with err_mode=00; level=4, full=1. Write a fifth value 0x11: ignored. Four reads give ack at +2 cycles each with data 0xA5, 0x3C, 0xFF, 0x00; then empty=1.
2. err_mode=01, write then read 0x5A: ack, data_out=0x5A, corr_cnt=1, level drops by 1.
3. err_mode=10, MAX_RETRY=3, write 0x77:
   - Reads 1 and 2: nack, level stays 1, data_out held.
   - Read 3: nack+drop, empty=1, uncorr_cnt=3, drop_cnt=1.
4. err_mode=11, write 0x81: read 1 nacks; read 2 acks with 0x81; uncorr_cnt=1, drop_cnt=0.
5. Fill to 4, then same-cycle wr_en and rd_en (0x42 pushed): level stays 4 throughout. After 6 more reads, order is preserved across the wrap, including 0x42.
6. Assert rst during DECODE: no ack/nack in the following cycles; all outputs at reset values. With FIFO_ARQ_STATS_EN undefined, the counters read 0 after scenarios 2–3.
